// File: rtl/bg_affine_sequencer.sv
// bg_affine_sequencer
//   Walks the visible frame for the affine backgrounds (BG2/BG3). For every
//   pixel of every scanline it names which background the rotation/scale
//   units should step this cycle, then issues one row-advance strobe per line.
//
// Parameters
//   WIDTH        pixels per scanline (default 240)
//   LINES        visible scanlines per frame (default 160)
//
// Ports
//   clock        single clock, all state on its rising edge
//   rst          asynchronous, active-high reset
//   frame_start  one-cycle pulse: (re)start a frame, from any state
//   line_start   one-cycle pulse: start the current scanline
//   bg2_en       BG2 enabled (sampled at pixel boundaries)
//   bg3_en       BG3 enabled (sampled at pixel boundaries)
//   stall        freeze PIXEL/ROWSTEP work (only with BG_AFFINE_STALL_EN)
//   bgno         background stepped this cycle, 0 = none
//   steprow      one-cycle row-advance strobe
//   newframe     one-cycle reference-point reload strobe
//   pix_x        pixel index of the current fetch
//   line_y       current line index
//   pix_valid    high exactly when bgno != 0
//   dbg_state    FSM state (0 IDLE, 1 WAIT_LINE, 2 PIXEL, 3 ROWSTEP, 4 DONE)
//
// Configuration
//   BG_AFFINE_STALL_EN  when defined, adds the stall input. A stall in
//                       PIXEL or ROWSTEP freezes the sequencer, blanks the
//                       strobes, and reissues the held sub-cycle on release.
//                       frame_start still takes effect while stalled.
//
// Every output is a register; the registered value describes the state just
// entered, so there is no combinational path from inputs to outputs.
module bg_affine_sequencer #(
  parameter int WIDTH = 240,
  parameter int LINES = 160
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       line_start,
  input  logic       bg2_en,
  input  logic       bg3_en,
`ifdef BG_AFFINE_STALL_EN
  input  logic       stall,
`endif
  output logic [1:0] bgno,
  output logic       steprow,
  output logic       newframe,
  output logic [7:0] pix_x,
  output logic [7:0] line_y,
  output logic       pix_valid,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LINE = 3'd1,
    S_PIXEL     = 3'd2,
    S_ROWSTEP   = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [7:0] LAST_X = 8'(WIDTH - 1);
  localparam logic [7:0] LAST_Y = 8'(LINES - 1);

  state_t     r_state;
  logic [1:0] r_sub;       // sub-cycle currently owned, kept across a stall
  logic       r_bg3_pend;  // current pixel still owes its BG3 sub-cycle
  logic       r_held;      // a stall blanked the current sub-cycle
  logic [1:0] r_bgno;
  logic       r_steprow;
  logic       r_newframe;
  logic [7:0] r_pix_x;
  logic [7:0] r_line_y;
  logic       r_pix_valid;
  logic       w_stall;

`ifdef BG_AFFINE_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  // First sub-cycle of a pixel: BG2 goes first when enabled.
  function automatic logic [1:0] first_sub(input logic e2, input logic e3);
    if (e2)      return 2'd2;
    else if (e3) return 2'd3;
    else         return 2'd0;
  endfunction

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sub       <= 2'd0;
      r_bg3_pend  <= 1'b0;
      r_held      <= 1'b0;
      r_bgno      <= 2'd0;
      r_steprow   <= 1'b0;
      r_newframe  <= 1'b0;
      r_pix_x     <= 8'd0;
      r_line_y    <= 8'd0;
      r_pix_valid <= 1'b0;
    end else begin
      r_newframe <= 1'b0;
      r_steprow  <= 1'b0;
      if (frame_start) begin
        // Starts a frame from IDLE/DONE and aborts any line in progress.
        r_state     <= S_WAIT_LINE;
        r_newframe  <= 1'b1;
        r_pix_x     <= 8'd0;
        r_line_y    <= 8'd0;
        r_sub       <= 2'd0;
        r_bg3_pend  <= 1'b0;
        r_held      <= 1'b0;
        r_bgno      <= 2'd0;
        r_pix_valid <= 1'b0;
      end else if (w_stall && (r_state == S_PIXEL || r_state == S_ROWSTEP)) begin
        r_held      <= 1'b1;
        r_bgno      <= 2'd0;
        r_pix_valid <= 1'b0;
      end else if (r_held) begin
        // Stall released: present the frozen sub-cycle again before moving on.
        r_held      <= 1'b0;
        r_bgno      <= r_sub;
        r_pix_valid <= (r_sub != 2'd0);
        r_steprow   <= (r_state == S_ROWSTEP);
      end else begin
        case (r_state)
          S_WAIT_LINE: begin
            if (line_start) begin
              r_pix_x <= 8'd0;
              if (bg2_en || bg3_en) begin
                r_state     <= S_PIXEL;
                r_sub       <= first_sub(bg2_en, bg3_en);
                r_bgno      <= first_sub(bg2_en, bg3_en);
                r_pix_valid <= 1'b1;
                r_bg3_pend  <= bg2_en & bg3_en;
              end else begin
                r_state     <= S_ROWSTEP;
                r_steprow   <= 1'b1;
                r_sub       <= 2'd0;
                r_bgno      <= 2'd0;
                r_pix_valid <= 1'b0;
              end
            end
          end
          S_PIXEL: begin
            if (r_bg3_pend) begin
              r_sub       <= 2'd3;
              r_bgno      <= 2'd3;
              r_pix_valid <= 1'b1;
              r_bg3_pend  <= 1'b0;
            end else if (r_pix_x == LAST_X) begin
              r_state     <= S_ROWSTEP;
              r_steprow   <= 1'b1;
              r_sub       <= 2'd0;
              r_bgno      <= 2'd0;
              r_pix_valid <= 1'b0;
            end else begin
              // Pixel boundary: the only place the enables are sampled.
              r_pix_x     <= r_pix_x + 8'd1;
              r_sub       <= first_sub(bg2_en, bg3_en);
              r_bgno      <= first_sub(bg2_en, bg3_en);
              r_pix_valid <= bg2_en | bg3_en;
              r_bg3_pend  <= bg2_en & bg3_en;
            end
          end
          S_ROWSTEP: begin
            // line_y advances modulo LINES so it never leaves 0..LINES-1.
            if (r_line_y == LAST_Y) begin
              r_line_y <= 8'd0;
              r_state  <= S_DONE;
            end else begin
              r_line_y <= r_line_y + 8'd1;
              r_state  <= S_WAIT_LINE;
            end
          end
          default: ;  // IDLE and DONE only leave on frame_start
        endcase
      end
    end
  end

  assign bgno      = r_bgno;
  assign steprow   = r_steprow;
  assign newframe  = r_newframe;
  assign pix_x     = r_pix_x;
  assign line_y    = r_line_y;
  assign pix_valid = r_pix_valid;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bg_affine_sequencer.sv
// Directed bench for bg_affine_sequencer (default WIDTH=240, LINES=160).
// Inputs are driven 1 ns after a rising edge; outputs are sampled there too,
// so every check sees the registered result of the edge just taken.
module tb_bg_affine_sequencer;

  localparam int ST_IDLE = 0, ST_WAIT = 1, ST_PIXEL = 2, ST_ROW = 3, ST_DONE = 4;

  logic       clock = 1'b0;
  logic       rst;
  logic       frame_start, line_start, bg2_en, bg3_en;
  logic [1:0] bgno;
  logic       steprow, newframe, pix_valid;
  logic [7:0] pix_x, line_y;
  logic [2:0] dbg_state;
`ifdef BG_AFFINE_STALL_EN
  logic       stall = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  bg_affine_sequencer dut (
    .clock       (clock),
    .rst         (rst),
    .frame_start (frame_start),
    .line_start  (line_start),
    .bg2_en      (bg2_en),
    .bg3_en      (bg3_en),
`ifdef BG_AFFINE_STALL_EN
    .stall       (stall),
`endif
    .bgno        (bgno),
    .steprow     (steprow),
    .newframe    (newframe),
    .pix_x       (pix_x),
    .line_y      (line_y),
    .pix_valid   (pix_valid),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_line();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".bgno"},      32'(bgno),      32'd0);
    check({tag, ".steprow"},   32'(steprow),   32'd0);
    check({tag, ".newframe"},  32'(newframe),  32'd0);
    check({tag, ".pix_valid"}, 32'(pix_valid), 32'd0);
  endtask

  // Bounded wait for the row strobe, then step past it into the next state.
  task automatic wait_steprow(input string tag);
    int n;
    n = 0;
    while (steprow !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    check(tag, 32'(steprow), 32'd1);
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rows;
    rst = 1'b1; frame_start = 1'b0; line_start = 1'b0; bg2_en = 1'b0; bg3_en = 1'b0;
    tick(); tick();
    check_quiet("reset");
    check("reset.pix_x",  32'(pix_x),     32'd0);
    check("reset.line_y", 32'(line_y),    32'd0);
    check("reset.state",  32'(dbg_state), ST_IDLE);
    rst = 1'b0;
    tick();

    // line_start before any frame_start does nothing
    bg2_en = 1'b1; bg3_en = 1'b1;
    pulse_line();
    for (int i = 0; i < 4; i++) begin
      check_quiet("idle_line_start");
      tick();
    end
    check("idle_line_start.state", 32'(dbg_state), ST_IDLE);

    // frame start
    pulse_frame();
    check("frame.newframe", 32'(newframe),  32'd1);
    check("frame.line_y",   32'(line_y),    32'd0);
    check("frame.state",    32'(dbg_state), ST_WAIT);
    check("frame.steprow",  32'(steprow),   32'd0);
    tick();
    check("frame.newframe_drop", 32'(newframe), 32'd0);

    // line 0: both enabled -> 2,3 per pixel, 480 cycles; a stray line_start is ignored
    pulse_line();
    for (int i = 0; i < 480; i++) begin
      check("both.bgno",      32'(bgno),      (i % 2 == 0) ? 32'd2 : 32'd3);
      check("both.pix_x",     32'(pix_x),     32'(i / 2));
      check("both.pix_valid", 32'(pix_valid), 32'd1);
      check("both.steprow",   32'(steprow),   32'd0);
      line_start = (i == 100);
      tick();
    end
    line_start = 1'b0;
    check("both.steprow_end", 32'(steprow),   32'd1);
    check("both.bgno_row",    32'(bgno),      32'd0);
    check("both.state_row",   32'(dbg_state), ST_ROW);
    tick();
    check("both.steprow_once", 32'(steprow),   32'd0);
    check("both.line_y",       32'(line_y),    32'd1);
    check("both.state_wait",   32'(dbg_state), ST_WAIT);

    // line 1: bg3 only -> 240 cycles of bgno=3
    bg2_en = 1'b0; bg3_en = 1'b1;
    pulse_line();
    for (int i = 0; i < 240; i++) begin
      check("bg3.bgno",  32'(bgno),  32'd3);
      check("bg3.pix_x", 32'(pix_x), 32'(i));
      tick();
    end
    check("bg3.steprow", 32'(steprow), 32'd1);
    tick();
    check("bg3.line_y", 32'(line_y), 32'd2);

    // line 2: enable changes take effect only at the pixel boundary
    bg2_en = 1'b1; bg3_en = 1'b1;
    pulse_line();
    check("mid.p0_bg2", 32'(bgno), 32'd2);
    bg3_en = 1'b0;
    tick();
    check("mid.p0_bg3_latched", 32'(bgno),  32'd3);
    check("mid.p0_x",           32'(pix_x), 32'd0);
    tick();
    check("mid.p1_bgno", 32'(bgno),  32'd2);
    check("mid.p1_x",    32'(pix_x), 32'd1);
    tick();
    check("mid.p2_x", 32'(pix_x), 32'd2);
    bg2_en = 1'b0;
    tick();
    check("none.p3_bgno",  32'(bgno),      32'd0);
    check("none.p3_valid", 32'(pix_valid), 32'd0);
    check("none.p3_x",     32'(pix_x),     32'd3);
    check("none.state",    32'(dbg_state), ST_PIXEL);
    tick();
    check("none.p4_x", 32'(pix_x), 32'd4);
    bg3_en = 1'b1;
    tick();
    check("none.p5_bgno", 32'(bgno),  32'd3);
    check("none.p5_x",    32'(pix_x), 32'd5);
    wait_steprow("line2.steprow");
    check("line2.line_y", 32'(line_y), 32'd3);

    // lines 3 and 4, then abort at pixel 100 of line 5
    pulse_line(); wait_steprow("line3.steprow");
    pulse_line(); wait_steprow("line4.steprow");
    check("line5.line_y", 32'(line_y), 32'd5);
    pulse_line();
    for (int i = 0; i < 100; i++) tick();
    check("abort.pre_x", 32'(pix_x), 32'd100);
    pulse_frame();
    check("abort.newframe", 32'(newframe),  32'd1);
    check("abort.steprow",  32'(steprow),   32'd0);
    check("abort.line_y",   32'(line_y),    32'd0);
    check("abort.pix_x",    32'(pix_x),     32'd0);
    check("abort.bgno",     32'(bgno),      32'd0);
    check("abort.state",    32'(dbg_state), ST_WAIT);
    tick();
    check("abort.no_late_steprow", 32'(steprow), 32'd0);

    // full frame of empty lines: 160 row strobes, then DONE
    bg2_en = 1'b0; bg3_en = 1'b0;
    rows = 0;
    for (int l = 0; l < 160; l++) begin
      pulse_line();
      if (steprow === 1'b1) rows++;
      tick();
      check("frame.line_y_step", 32'(line_y), 32'((l + 1) % 160));
    end
    check("frame.steprow_count", 32'(rows),      32'd160);
    check("frame.done",          32'(dbg_state), ST_DONE);
    bg3_en = 1'b1;
    pulse_line();
    for (int i = 0; i < 3; i++) begin
      check_quiet("done.line_start");
      tick();
    end
    check("done.state_hold", 32'(dbg_state), ST_DONE);
    pulse_frame();
    check("done.newframe", 32'(newframe),  32'd1);
    check("done.line_y",   32'(line_y),    32'd0);
    check("done.state",    32'(dbg_state), ST_WAIT);

    // reset mid-PIXEL
    bg2_en = 1'b1; bg3_en = 1'b0;
    pulse_line();
    for (int i = 0; i < 5; i++) tick();
    check("rst.pre_bgno", 32'(bgno), 32'd2);
    #2 rst = 1'b1;
    #1 check_quiet("rst.async");
    tick();
    check_quiet("rst.edge");
    check("rst.pix_x", 32'(pix_x),     32'd0);
    check("rst.state", 32'(dbg_state), ST_IDLE);
    rst = 1'b0;
    tick();
    pulse_line();
    for (int i = 0; i < 4; i++) begin
      check_quiet("rst.line_start");
      tick();
    end
    check("rst.still_idle", 32'(dbg_state), ST_IDLE);

`ifdef BG_AFFINE_STALL_EN
    // stall during the BG3 sub-cycle of pixel 10
    bg2_en = 1'b1; bg3_en = 1'b1;
    pulse_frame();
    pulse_line();
    for (int i = 0; i < 21; i++) tick();
    check("stall.pre_bgno", 32'(bgno),  32'd3);
    check("stall.pre_x",    32'(pix_x), 32'd10);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.bgno",  32'(bgno),      32'd0);
      check("stall.valid", 32'(pix_valid), 32'd0);
      check("stall.x",     32'(pix_x),     32'd10);
    end
    stall = 1'b0;
    tick();
    check("stall.reissue_bgno", 32'(bgno),  32'd3);
    check("stall.reissue_x",    32'(pix_x), 32'd10);
    tick();
    check("stall.next_bgno", 32'(bgno),  32'd2);
    check("stall.next_x",    32'(pix_x), 32'd11);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bg_affine_sequencer.md
BG_AFFINE_SEQUENCER -- requirements
Module: bg_affine_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 240, meaning pixels per scanline.
REQ-002 SHALL have parameter LINES, default 160, meaning visible scanlines per frame.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse that starts a new frame.
REQ-006 SHALL have port line_start  input  1  one-cycle pulse that starts the current scanline.
REQ-007 SHALL have port bg2_en, bg3_en  input  1 each  affine BG2/BG3 enabled.
REQ-008 SHALL have port bgno  output  2  background selected for stepping this cycle; 2'd0 = none.
REQ-009 SHALL have port steprow  output  1  one-cycle row-advance strobe to the rotation/scale units.
REQ-010 SHALL have port newframe  output  1  one-cycle reference-point reload strobe.
REQ-011 SHALL have port pix_x  output  8  pixel index of the current fetch, 0..WIDTH-1.
REQ-012 SHALL have port line_y  output  8  current line index, 0..LINES-1.
REQ-013 SHALL have port pix_valid  output  1  bgno is nonzero and pix_x/line_y are valid.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT_LINE, PIXEL, ROWSTEP and DONE.
REQ-015 IDLE: SHALL go to WAIT_LINE on frame_start, with newframe=1 that same cycle and line_y cleared to 0.
REQ-016 WAIT_LINE: SHALL go to PIXEL on line_start when bg2_en or bg3_en is 1; otherwise SHALL go directly to ROWSTEP.
REQ-017 PIXEL: for each pixel, SHALL drive bgno=2 for one cycle if bg2_en=1, then bgno=3 for one cycle if bg3_en=1; pix_x SHALL stay constant across both cycles.
REQ-018 Pixel cost SHALL be 2 cycles with both enabled and 1 cycle with exactly one enabled.
REQ-019 After the last sub-cycle of pixel WIDTH-1, SHALL go to ROWSTEP.
REQ-020 ROWSTEP: SHALL assert steprow for exactly one cycle and drive bgno=0.
REQ-021 From ROWSTEP, SHALL increment line_y; if the old line_y was LINES-1, SHALL go to DONE, else to WAIT_LINE.
REQ-022 DONE: SHALL ignore line_start and go to WAIT_LINE on frame_start, with newframe=1 and line_y=0.
REQ-023 frame_start in any state other than IDLE/DONE SHALL abort the line, pulse newframe, clear pix_x and line_y, suppress steprow that cycle, and enter WAIT_LINE.
REQ-024 line_start while in PIXEL or ROWSTEP SHALL be ignored.
REQ-025 bg2_en/bg3_en SHALL be sampled only at each pixel boundary; a change mid-pixel SHALL take effect on the next pixel.
REQ-026 If both enables are 0 at a pixel boundary within PIXEL, SHALL drive bgno=0, advance pix_x one pixel per cycle, and hold pix_valid=0.
REQ-027 pix_valid SHALL be 1 exactly when bgno != 0.
REQ-028 newframe and steprow SHALL never be asserted in the same cycle.
REQ-029 All outputs SHALL be registered (Moore), with no combinational path from inputs to outputs.

Reset
REQ-030 While rst=1: state=IDLE, bgno=0, steprow=0, newframe=0, pix_x=0, line_y=0, pix_valid=0.
REQ-031 rst asserted mid-line SHALL abort immediately with no steprow or newframe strobe, and the first activity after release SHALL require frame_start.

Configuration
REQ-032 Macro BG_AFFINE_STALL_EN SHALL control an extra stall input port (input, 1 bit).
REQ-033 With BG_AFFINE_STALL_EN defined: stall=1 in PIXEL or ROWSTEP SHALL freeze all state and counters and force bgno=0, steprow=0 and pix_valid=0; the held sub-cycle SHALL reissue after stall drops.
REQ-034 With BG_AFFINE_STALL_EN defined: stall SHALL NOT delay newframe or frame_start handling.
REQ-035 Without BG_AFFINE_STALL_EN: the stall port SHALL be absent and behaviour SHALL be as REQ-014..REQ-031.

Verification
REQ-036 Both enables, frame_start, then line_start -> bgno sequence 2,3 per pixel for 480 cycles; pix_x 0..239; then one steprow; line_y=1.
REQ-037 Only bg3_en=1 -> 240 cycles of bgno=3; pix_x increments every cycle; then steprow.
REQ-038 160 full lines -> 160 steprow pulses, then DONE; further line_start produces no activity until frame_start, which gives newframe=1 and line_y=0.
REQ-039 frame_start at pix_x=100 of line 5 -> newframe=1, no steprow, line_y=0, state WAIT_LINE.
REQ-040 rst pulse mid-PIXEL -> all outputs 0 next edge; line_start before any frame_start -> no bgno activity.
REQ-041 (BG_AFFINE_STALL_EN) stall for 3 cycles during the bgno=3 sub-cycle of pixel 10 -> bgno=0 for 3 cycles, then bgno=3 at pix_x=10, then bgno=2 at pix_x=11.
